// File: rtl/risc_spm_pkg.sv
// ==== risc_spm_pkg : shared encodings for the RISC-SPM v2 control unit | rev 1.0 ====
`default_nettype none

package risc_spm_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;
  localparam logic [3:0] OP_BRC = 4'd9;
  localparam logic [3:0] OP_BRN = 4'd10;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  function automatic int num_regs(input int reg_addr_w);
    return 1 << reg_addr_w;
  endfunction

  // Bus-1 select needs one code beyond the register file for the PC.
  function automatic int sel1_width(input int reg_addr_w);
    return reg_addr_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc_spm_ctrl_v2_if.sv
// ==== risc_spm_ctrl_v2_if : control-unit <-> datapath/memory signal bundle | rev 1.0 ====
`default_nettype none

interface risc_spm_ctrl_v2_if
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int REG_ADDR_W = 2
);
  localparam int NUM_REGS = num_regs(REG_ADDR_W);
  localparam int SEL1_W   = sel1_width(REG_ADDR_W);

  logic [WORD_SIZE-1:0] instruction;
  logic                 zero;
  logic                 carry;
  logic                 neg;
  logic                 mem_ready;
  logic                 resume;

  logic [NUM_REGS-1:0]  Load_R;
  logic                 Load_PC;
  logic                 Inc_PC;
  logic                 Load_IR;
  logic                 Load_Add_R;
  logic                 Load_Reg_Y;
  logic                 Load_Reg_Z;
  logic [SEL1_W-1:0]    Sel_Bus_1_Mux;
  logic [1:0]           Sel_Bus_2_Mux;
  logic                 mem_req;
  logic                 write;
  logic                 halted;
  logic                 illegal;

  modport master (
    input  instruction, zero, carry, neg, mem_ready, resume,
    output Load_R, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_req, write, halted, illegal
  );

  modport slave (
    output instruction, zero, carry, neg, mem_ready, resume,
    input  Load_R, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_req, write, halted, illegal
  );

endinterface

`default_nettype wire

// File: rtl/risc_spm_reg_onehot.sv
// ==== risc_spm_reg_onehot : register address to one-hot load strobe decoder | rev 1.0 ====
`default_nettype none

module risc_spm_reg_onehot
  import risc_spm_pkg::*;
#(
  parameter int REG_ADDR_W = 2
) (
  input  wire logic [REG_ADDR_W-1:0]           addr,
  input  wire logic                            en,
  output logic [num_regs(REG_ADDR_W)-1:0]      onehot
);

  for (genvar i = 0; i < num_regs(REG_ADDR_W); i++) begin : g_bit
    assign onehot[i] = en && (addr == REG_ADDR_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/risc_spm_ctrl_v2.sv
// ==== risc_spm_ctrl_v2 : fetch/decode/execute sequencer with wait states, HLT and traps | rev 1.0 ====
`default_nettype none

module risc_spm_ctrl_v2
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int OP_SIZE    = 4,
  parameter int REG_ADDR_W = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  risc_spm_ctrl_v2_if.master  bus
);

  localparam int                SEL1_W  = sel1_width(REG_ADDR_W);
  localparam logic [SEL1_W-1:0] SEL1_PC = SEL1_W'(num_regs(REG_ADDR_W));

  state_t                  state;
  state_t                  state_next;
  logic                    illegal_q;
  logic                    set_illegal;
  logic                    load_r_en;
  logic                    cond_flag;
  logic [OP_SIZE-1:0]      opcode;
  logic [REG_ADDR_W-1:0]   src;
  logic [REG_ADDR_W-1:0]   dest;

  assign opcode = bus.instruction[WORD_SIZE-1 -: OP_SIZE];
  assign src    = bus.instruction[2*REG_ADDR_W-1 : REG_ADDR_W];
  assign dest   = bus.instruction[REG_ADDR_W-1 : 0];

  assign cond_flag = (opcode == OP_SIZE'(OP_BRZ)) ? bus.zero  :
                     (opcode == OP_SIZE'(OP_BRC)) ? bus.carry : bus.neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  // Memory states hold until mem_ready; selects and mem_req stay up while strobes wait for the ready cycle.
  always_comb begin
    state_next        = state;
    set_illegal       = 1'b0;
    load_r_en         = 1'b0;
    bus.Load_PC       = 1'b0;
    bus.Inc_PC        = 1'b0;
    bus.Load_IR       = 1'b0;
    bus.Load_Add_R    = 1'b0;
    bus.Load_Reg_Y    = 1'b0;
    bus.Load_Reg_Z    = 1'b0;
    bus.Sel_Bus_1_Mux = '0;
    bus.Sel_Bus_2_Mux = SEL2_ALU;
    bus.mem_req       = 1'b0;
    bus.write         = 1'b0;
    bus.halted        = 1'b0;

    case (state)
      S_IDLE: state_next = S_FET1;
      S_FET1: begin
        bus.Sel_Bus_1_Mux = SEL1_PC;
        bus.Sel_Bus_2_Mux = SEL2_BUS1;
        bus.Load_Add_R    = 1'b1;
        state_next        = S_FET2;
      end
      S_FET2: begin
        bus.mem_req       = 1'b1;
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        if (bus.mem_ready) begin
          bus.Load_IR = 1'b1;
          bus.Inc_PC  = 1'b1;
          state_next  = S_DEC;
        end
      end
      S_DEC: begin
        case (opcode)
          OP_SIZE'(OP_NOP): state_next = S_FET1;
          OP_SIZE'(OP_ADD), OP_SIZE'(OP_SUB), OP_SIZE'(OP_AND): begin
            bus.Sel_Bus_1_Mux = {1'b0, src};
            bus.Sel_Bus_2_Mux = SEL2_BUS1;
            bus.Load_Reg_Y    = 1'b1;
            state_next        = S_EX1;
          end
          OP_SIZE'(OP_NOT): begin
            bus.Sel_Bus_1_Mux = {1'b0, src};
            bus.Sel_Bus_2_Mux = SEL2_ALU;
            bus.Load_Reg_Z    = 1'b1;
            load_r_en         = 1'b1;
            state_next        = S_FET1;
          end
          OP_SIZE'(OP_RD), OP_SIZE'(OP_WR), OP_SIZE'(OP_BR): begin
            bus.Sel_Bus_1_Mux = SEL1_PC;
            bus.Sel_Bus_2_Mux = SEL2_BUS1;
            bus.Load_Add_R    = 1'b1;
            state_next        = (opcode == OP_SIZE'(OP_RD)) ? S_RD1 :
                                (opcode == OP_SIZE'(OP_WR)) ? S_WR1 : S_BR1;
          end
          OP_SIZE'(OP_BRZ), OP_SIZE'(OP_BRC), OP_SIZE'(OP_BRN): begin
            if (cond_flag) begin
              bus.Sel_Bus_1_Mux = SEL1_PC;
              bus.Sel_Bus_2_Mux = SEL2_BUS1;
              bus.Load_Add_R    = 1'b1;
              state_next        = S_BR1;
            end else begin
              // Not taken: step the PC over the branch target word.
              bus.Inc_PC = 1'b1;
              state_next = S_FET1;
            end
          end
          OP_SIZE'(OP_HLT): state_next = S_HALT;
          default: begin
            set_illegal = 1'b1;
            state_next  = S_HALT;
          end
        endcase
      end
      S_EX1: begin
        bus.Sel_Bus_1_Mux = {1'b0, dest};
        bus.Sel_Bus_2_Mux = SEL2_ALU;
        bus.Load_Reg_Z    = 1'b1;
        load_r_en         = 1'b1;
        state_next        = S_FET1;
      end
      S_RD1, S_WR1: begin
        bus.mem_req       = 1'b1;
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        if (bus.mem_ready) begin
          bus.Load_Add_R = 1'b1;
          bus.Inc_PC     = 1'b1;
          state_next     = (state == S_RD1) ? S_RD2 : S_WR2;
        end
      end
      S_RD2: begin
        bus.mem_req       = 1'b1;
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        if (bus.mem_ready) begin
          load_r_en  = 1'b1;
          state_next = S_FET1;
        end
      end
      S_WR2: begin
        bus.mem_req       = 1'b1;
        bus.Sel_Bus_1_Mux = {1'b0, src};
        bus.write         = 1'b1;
        if (bus.mem_ready) state_next = S_FET1;
      end
      S_BR1: begin
        bus.mem_req       = 1'b1;
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        if (bus.mem_ready) begin
          bus.Load_Add_R = 1'b1;
          state_next     = S_BR2;
        end
      end
      S_BR2: begin
        bus.mem_req       = 1'b1;
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        if (bus.mem_ready) begin
          bus.Load_PC = 1'b1;
          state_next  = S_FET1;
        end
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (bus.resume && !illegal_q) state_next = S_FET1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.illegal = illegal_q;

  risc_spm_reg_onehot #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_r (
    .addr   (dest),
    .en     (load_r_en),
    .onehot (bus.Load_R)
  );

endmodule

`default_nettype wire

// File: tb/tb_risc_spm_ctrl_v2.sv
// ==== tb_risc_spm_ctrl_v2 : instruction-level model check of the RISC-SPM v2 control unit | rev 1.0 ====
`default_nettype none

module tb_risc_spm_ctrl_v2;

  typedef struct packed {
    logic [7:0] load_r;
    logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
    logic [3:0] sel1;
    logic [1:0] sel2;
    logic       mem_req, write, halted, illegal;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  mem;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc_spm_ctrl_v2_if #(.WORD_SIZE(8),  .REG_ADDR_W(2)) bn ();
  risc_spm_ctrl_v2_if #(.WORD_SIZE(10), .REG_ADDR_W(3)) bw ();

  risc_spm_ctrl_v2 #(.WORD_SIZE(8),  .OP_SIZE(4), .REG_ADDR_W(2)) dut_n (.clk(clk), .rst(rst), .bus(bn));
  risc_spm_ctrl_v2 #(.WORD_SIZE(10), .OP_SIZE(4), .REG_ADDR_W(3)) dut_w (.clk(clk), .rst(rst), .bus(bw));

  int    n_checks = 0;
  int    n_pass   = 0;
  bit    m_illegal;
  step_t plan_q[$];
  outs_t obs_q[$];
  outs_t exp_q[$];

  task automatic drive(input logic [9:0] instr, input logic z, c, n, mr, res);
    bn.instruction = instr[7:0]; bw.instruction = instr;
    bn.zero = z;       bw.zero = z;
    bn.carry = c;      bw.carry = c;
    bn.neg = n;        bw.neg = n;
    bn.mem_ready = mr; bw.mem_ready = mr;
    bn.resume = res;   bw.resume = res;
  endtask

  function automatic outs_t sample(input bit wide);
    outs_t o;
    o = '0;
    if (wide) begin
      o.load_r = bw.Load_R; o.sel1 = bw.Sel_Bus_1_Mux; o.sel2 = bw.Sel_Bus_2_Mux;
      o.load_pc = bw.Load_PC; o.inc_pc = bw.Inc_PC; o.load_ir = bw.Load_IR;
      o.load_add_r = bw.Load_Add_R; o.load_reg_y = bw.Load_Reg_Y; o.load_reg_z = bw.Load_Reg_Z;
      o.mem_req = bw.mem_req; o.write = bw.write; o.halted = bw.halted; o.illegal = bw.illegal;
    end else begin
      o.load_r = {4'b0, bn.Load_R}; o.sel1 = {1'b0, bn.Sel_Bus_1_Mux}; o.sel2 = bn.Sel_Bus_2_Mux;
      o.load_pc = bn.Load_PC; o.inc_pc = bn.Inc_PC; o.load_ir = bn.Load_IR;
      o.load_add_r = bn.Load_Add_R; o.load_reg_y = bn.Load_Reg_Y; o.load_reg_z = bn.Load_Reg_Z;
      o.mem_req = bn.mem_req; o.write = bn.write; o.halted = bn.halted; o.illegal = bn.illegal;
    end
    return o;
  endfunction

  task automatic step_cycle(input bit wide, input logic [9:0] instr, input logic z, c, n, mr, res,
                            output outs_t o);
    @(negedge clk);
    drive(instr, z, c, n, mr, res);
    #1;
    o = sample(wide);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_illegal = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Instruction-level table: one entry per cycle an instruction spends from fet1 through its last step.
  task automatic make_plan(input bit wide, input logic [9:0] instr, input logic z, c, n);
    int    rw, ws, op, src, dst, pc;
    bit    taken;
    outs_t b, s;
    rw  = wide ? 3 : 2;
    ws  = wide ? 10 : 8;
    op  = int'(instr >> (ws - 4)) & 15;
    src = int'(instr >> rw) & ((1 << rw) - 1);
    dst = int'(instr) & ((1 << rw) - 1);
    pc  = 1 << rw;
    plan_q.delete();
    b = '0;
    b.illegal = m_illegal;
    s = b; s.sel1 = 4'(pc); s.sel2 = 2'd1; s.load_add_r = 1'b1; plan_q.push_back('{s, 1'b0});
    s = b; s.mem_req = 1'b1; s.sel2 = 2'd2; s.load_ir = 1'b1; s.inc_pc = 1'b1; plan_q.push_back('{s, 1'b1});
    taken = (op >= 5 && op <= 7) || (op == 8 && z) || (op == 9 && c) || (op == 10 && n);
    s = b;
    if (op >= 1 && op <= 3) begin
      s.sel1 = 4'(src); s.sel2 = 2'd1; s.load_reg_y = 1'b1; plan_q.push_back('{s, 1'b0});
      s = b; s.sel1 = 4'(dst); s.load_reg_z = 1'b1; s.load_r = 8'(1 << dst); plan_q.push_back('{s, 1'b0});
    end else if (op == 4) begin
      s.sel1 = 4'(src); s.load_reg_z = 1'b1; s.load_r = 8'(1 << dst); plan_q.push_back('{s, 1'b0});
    end else if (taken) begin
      s.sel1 = 4'(pc); s.sel2 = 2'd1; s.load_add_r = 1'b1; plan_q.push_back('{s, 1'b0});
      s = b; s.mem_req = 1'b1; s.sel2 = 2'd2; s.load_add_r = 1'b1; s.inc_pc = (op != 7 && op < 8);
      plan_q.push_back('{s, 1'b1});
      s = b; s.mem_req = 1'b1;
      if (op == 5) begin s.sel2 = 2'd2; s.load_r = 8'(1 << dst); end
      else if (op == 6) begin s.sel1 = 4'(src); s.write = 1'b1; end
      else begin s.sel2 = 2'd2; s.load_pc = 1'b1; end
      plan_q.push_back('{s, 1'b1});
    end else if (op >= 8 && op <= 10) begin
      s.inc_pc = 1'b1; plan_q.push_back('{s, 1'b0});
    end else begin
      plan_q.push_back('{s, 1'b0});
    end
  endtask

  // Runs one instruction; wait_n stalls are inserted at plan step wait_step, or random stalls if rnd.
  task automatic exec_plan(input bit wide, input logic [9:0] instr, input logic z, c, n,
                           input int wait_step, input int wait_n, input bit rnd);
    make_plan(wide, instr, z, c, n);
    foreach (plan_q[k]) begin
      int waits;
      waits = 0;
      for (int t = 0; t < 40; t++) begin
        logic  mr;
        outs_t o, e;
        if (rnd) mr = (waits < 8) ? ($urandom_range(0, 9) < 7) : 1'b1;
        else     mr = (k == wait_step && waits < wait_n) ? 1'b0 : 1'b1;
        step_cycle(wide, instr, z, c, n, mr, 1'b0, o);
        e = plan_q[k].o;
        if (plan_q[k].mem && !mr) begin
          e.load_r = '0; e.load_pc = 1'b0; e.inc_pc = 1'b0; e.load_ir = 1'b0;
          e.load_add_r = 1'b0; e.load_reg_y = 1'b0; e.load_reg_z = 1'b0;
        end
        obs_q.push_back(o);
        exp_q.push_back(e);
        if (!plan_q[k].mem || mr) break;
        waits++;
      end
    end
  endtask

  task automatic test_reset;
    outs_t o;
    do_reset();
    #1;
    o = sample(1'b0);
    n_checks++;
    if (o !== outs_t'(0)) $display("FAIL reset_idle_n got %h want 0", o); else n_pass++;
    o = sample(1'b1);
    n_checks++;
    if (o !== outs_t'(0)) $display("FAIL reset_idle_w got %h want 0", o); else n_pass++;
  endtask

  task automatic test_nop;
    do_reset();
    exec_plan(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    exec_plan(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL nop cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_add;
    do_reset();
    exec_plan(1'b0, 10'h016, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL add cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_q.size() != 4 || obs_q[3].load_r !== 8'h04 || obs_q[3].sel1 !== 4'd2)
      $display("FAIL add_ex1 got len %0d ex1 %h want load_r 04 sel1 2", obs_q.size(), obs_q[obs_q.size()-1]);
    else n_pass++;
  endtask

  task automatic test_rd_wait;
    do_reset();
    exec_plan(1'b0, 10'h053, 1'b0, 1'b0, 1'b0, 3, 3, 1'b0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rd_wait cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_q[obs_q.size()-1].load_r !== 8'h08)
      $display("FAIL rd_load_r got %h want 08", obs_q[obs_q.size()-1].load_r);
    else n_pass++;
  endtask

  task automatic test_brc;
    do_reset();
    exec_plan(1'b0, 10'h090, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0);
    exec_plan(1'b0, 10'h090, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
    exec_plan(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL brc cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_q.size() != 11) $display("FAIL brc_latency got %0d want 11", obs_q.size()); else n_pass++;
  endtask

  task automatic test_illegal;
    outs_t o, e;
    do_reset();
    exec_plan(1'b0, 10'h0B0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    m_illegal = 1'b1;
    e = '0; e.halted = 1'b1; e.illegal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b0, 10'h0B0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
      obs_q.push_back(o);
      exp_q.push_back(e);
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL illegal cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    do_reset();
    #1;
    o = sample(1'b0);
    n_checks++;
    if (o !== outs_t'(0)) $display("FAIL illegal_cleared got %h want 0", o); else n_pass++;
  endtask

  task automatic test_hlt_resume;
    outs_t o, e;
    do_reset();
    exec_plan(1'b0, 10'h0F0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    e = '0; e.halted = 1'b1;
    step_cycle(1'b0, 10'h0F0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    obs_q.push_back(o); exp_q.push_back(e);
    step_cycle(1'b0, 10'h0F0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
    obs_q.push_back(o); exp_q.push_back(e);
    exec_plan(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL hlt_resume cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wide;
    do_reset();
    exec_plan(1'b1, 10'h12E, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    exec_plan(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wide cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_q[0].sel1 !== 4'd8 || obs_q[2].sel1 !== 4'd5 || obs_q[2].load_r !== 8'h40)
      $display("FAIL wide_not got pc %0d sel1 %0d load_r %h want 8 5 40",
               obs_q[0].sel1, obs_q[2].sel1, obs_q[2].load_r);
    else n_pass++;
  endtask

  task automatic test_midwait_reset;
    outs_t o;
    do_reset();
    step_cycle(1'b0, 10'h053, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    step_cycle(1'b0, 10'h053, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    step_cycle(1'b0, 10'h053, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, o);
    step_cycle(1'b0, 10'h053, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o);
    n_checks++;
    if (o.mem_req !== 1'b1 || o.inc_pc !== 1'b0 || o.load_add_r !== 1'b0)
      $display("FAIL rd1_stall got %h want mem_req only", o);
    else n_pass++;
    rst = 1'b1;
    bn.mem_ready = 1'b1;
    bw.mem_ready = 1'b1;
    step_cycle(1'b0, 10'h053, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
    rst = 1'b0;
    n_checks++;
    if (o !== outs_t'(0)) $display("FAIL midwait_reset got %h want 0", o); else n_pass++;
    exec_plan(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL after_reset cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    for (int w = 0; w < 2; w++) begin
      int rw, ws;
      rw = (w == 1) ? 3 : 2;
      ws = (w == 1) ? 10 : 8;
      do_reset();
      for (int j = 0; j < 25; j++) begin
        int         op;
        logic [9:0] instr;
        op    = int'($urandom_range(0, 10));
        instr = 10'((op << (ws - 4)) | int'($urandom_range(0, (1 << (2 * rw)) - 1)));
        exec_plan(w == 1, instr, 1'($urandom), 1'($urandom), 1'($urandom), -1, 0, 1'b1);
      end
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL b2b w%0d cyc%0d got %h want %h", w, i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_nop();
    test_add();
    test_rd_wait();
    test_brc();
    test_illegal();
    test_hlt_resume();
    test_wide();
    test_midwait_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
